// File: rtl/exp_timer.sv
// Exposure timer: latches a clamped ms setting, drives Expose for that many ms, then pulses Done.
// Optional macro EXP_TIMER_CONT_EN adds the Cont input for back-to-back repeat exposures.
module exp_timer #(
  parameter int CLK_PER_MS = 1000,
  parameter int EXP_MIN    = 2,
  parameter int EXP_MAX    = 30
) (
  input  logic       Clk,
  input  logic       Reset,
`ifdef EXP_TIMER_CONT_EN
  input  logic       Cont,
`endif
  input  logic       Start,
  input  logic       Abort,
  input  logic [4:0] Exp_Time,
  output logic       Expose,
  output logic       Done,
  output logic       Busy,
  output logic [4:0] Ms_Left
);

  localparam int PW = $clog2(CLK_PER_MS);
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_PER_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_EXPOSE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [PW-1:0]   presc_r, presc_nxt_s;
  logic [4:0]      ms_left_r, ms_nxt_s;
  logic            expose_r, done_r, busy_r;
  logic            cont_s;

  function automatic logic [4:0] clamp_exp(input logic [4:0] t);
    if (t < 5'(EXP_MIN)) begin
      clamp_exp = 5'(EXP_MIN);
    end else if (t > 5'(EXP_MAX)) begin
      clamp_exp = 5'(EXP_MAX);
    end else begin
      clamp_exp = t;
    end
  endfunction

`ifdef EXP_TIMER_CONT_EN
  assign cont_s = Cont;
`else
  assign cont_s = 1'b0;
`endif

  // Next-state, prescaler and ms countdown
  always_comb begin
    state_nxt_s = state_r;
    presc_nxt_s = presc_r;
    ms_nxt_s    = ms_left_r;
    case (state_r)
      ST_IDLE: begin
        presc_nxt_s = '0;
        ms_nxt_s    = 5'd0;
        if (Start && !Abort) begin
          state_nxt_s = ST_ARM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        presc_nxt_s = '0;
        if (Abort) begin
          state_nxt_s = ST_IDLE;
          ms_nxt_s    = 5'd0;
        end else begin
          state_nxt_s = ST_EXPOSE;
          ms_nxt_s    = clamp_exp(Exp_Time);
        end
      end
      ST_EXPOSE: begin
        if (Abort) begin
          state_nxt_s = ST_IDLE;
          presc_nxt_s = '0;
          ms_nxt_s    = 5'd0;
        end else if (presc_r == PRE_TC) begin
          presc_nxt_s = '0;
          // Last ms finishing: the decrement to zero coincides with entering DONE
          if (ms_left_r == 5'd1) begin
            state_nxt_s = ST_DONE;
            ms_nxt_s    = 5'd0;
          end else begin
            state_nxt_s = ST_EXPOSE;
            ms_nxt_s    = ms_left_r - 5'd1;
          end
        end else begin
          state_nxt_s = ST_EXPOSE;
          presc_nxt_s = presc_r + PW'(1);
        end
      end
      ST_DONE: begin
        presc_nxt_s = '0;
        ms_nxt_s    = 5'd0;
        if (cont_s && !Abort) begin
          state_nxt_s = ST_ARM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        presc_nxt_s = '0;
        ms_nxt_s    = 5'd0;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r   <= ST_IDLE;
      presc_r   <= '0;
      ms_left_r <= 5'd0;
      expose_r  <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      presc_r   <= presc_nxt_s;
      ms_left_r <= ms_nxt_s;
      expose_r  <= (state_nxt_s == ST_EXPOSE);
      done_r    <= (state_nxt_s == ST_DONE);
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign Expose  = expose_r;
  assign Done    = done_r;
  assign Busy    = busy_r;
  assign Ms_Left = ms_left_r;

endmodule

// File: tb/tb_exp_timer.sv
// Randomized scoreboard bench for exp_timer; expected exposure records are queued by stimulus
// and checked by an independent monitor. Cont repeat test runs when EXP_TIMER_CONT_EN is defined.
module tb_exp_timer;

  localparam int CPM  = 4;
  localparam int EMIN = 2;
  localparam int EMAX = 30;

  logic       Clk, Reset, Start, Abort;
  logic [4:0] Exp_Time;
  logic       Expose, Done, Busy;
  logic [4:0] Ms_Left;
`ifdef EXP_TIMER_CONT_EN
  logic       Cont;
`endif

  exp_timer #(.CLK_PER_MS(CPM), .EXP_MIN(EMIN), .EXP_MAX(EMAX)) dut (
    .Clk(Clk),
    .Reset(Reset),
`ifdef EXP_TIMER_CONT_EN
    .Cont(Cont),
`endif
    .Start(Start),
    .Abort(Abort),
    .Exp_Time(Exp_Time),
    .Expose(Expose),
    .Done(Done),
    .Busy(Busy),
    .Ms_Left(Ms_Left)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int t_cl;
    int len;
    int done;
    int busy;
  } exp_rec_t;

  exp_rec_t sb_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int clamp_model(input int t);
    if (t < EMIN) return EMIN;
    if (t > EMAX) return EMAX;
    return t;
  endfunction

  // Monitor: measures Expose/Busy windows and Done pulses, compares against queued records
  bit mon_en = 1'b1;
  bit exp_win = 1'b0;
  bit busy_win = 1'b0;
  int idx = 0, bcnt = 0, dcnt = 0;

  always @(negedge Clk) begin
    if (!mon_en) begin
      exp_win = 1'b0; busy_win = 1'b0; bcnt = 0; dcnt = 0;
    end else if (!Reset) begin
      if (busy_win && sb_q.size() > 0) sb_q.delete(0);
      exp_win = 1'b0; busy_win = 1'b0; bcnt = 0; dcnt = 0;
    end else begin
      if (Expose) begin
        if (!exp_win) begin
          exp_win = 1'b1;
          idx = 0;
          if (sb_q.size() == 0) chk("unexpected_expose", 1, 0);
        end
        if (sb_q.size() > 0) chk("ms_left", int'(Ms_Left), sb_q[0].t_cl - idx / CPM);
        idx++;
      end else if (exp_win) begin
        exp_win = 1'b0;
        if (sb_q.size() > 0) begin
          chk("expose_len", idx, sb_q[0].len);
          chk("done_at_fall", int'(Done), sb_q[0].done);
          chk("ms_left_end", int'(Ms_Left), 0);
        end
      end
      if (Busy) begin
        busy_win = 1'b1;
        bcnt++;
        if (Done) dcnt++;
      end else begin
        if (Done) chk("stray_done", 1, 0);
        if (busy_win) begin
          busy_win = 1'b0;
          if (sb_q.size() == 0) chk("unexpected_busy", 1, 0);
          else begin
            chk("busy_len", bcnt, sb_q[0].busy);
            chk("done_count", dcnt, sb_q[0].done);
            sb_q.delete(0);
          end
          bcnt = 0; dcnt = 0;
        end
      end
    end
  end

  // One exposure request; k = EXPOSE/ARM cycle index to abort (-1 none), sb = cycle to re-pulse Start
  task automatic run(input int t, input int k, input int sb);
    exp_rec_t r;
    int tc, len;
    tc  = clamp_model(t);
    len = tc * CPM;
    r.t_cl = tc;
    if (k >= 0 && k <= len) begin
      r.len = k; r.done = 0; r.busy = k + 1;
    end else begin
      r.len = len; r.done = 1; r.busy = len + 2;
    end
    sb_q.push_back(r);
    @(posedge Clk); #1;
    Start = 1'b1; Abort = 1'b0; Exp_Time = 5'(t);
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 0; c <= len + 1; c++) begin
      Abort = (c == k);
      Start = (c == sb);
      if (c >= 1) Exp_Time = 5'($urandom_range(0, 31));
      @(posedge Clk); #1;
      if (c == k && k <= len) break;
    end
    Abort = 1'b0; Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0; Exp_Time = 5'd0;
`ifdef EXP_TIMER_CONT_EN
    Cont = 1'b0;
`endif
    #12;
    chk("rst_expose", int'(Expose), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_ms_left", int'(Ms_Left), 0);
    #5 Reset = 1'b1;

    run(5, -1, -1);
    run(0, -1, -1);
    run(31, -1, -1);
    run(3, -1, -1);
    run(5, 7, -1);
    run(5, -1, 4);
    run(2, -1, 9);
    run(4, 17, -1);
    run(6, 0, -1);

    // Start and Abort together in IDLE
    @(posedge Clk); #1;
    Start = 1'b1; Abort = 1'b1; Exp_Time = 5'd5;
    @(posedge Clk); #1;
    Start = 1'b0; Abort = 1'b0;
    @(posedge Clk); #1;
    chk("start_abort_busy", int'(Busy), 0);
    chk("start_abort_expose", int'(Expose), 0);

    // Reset on the 5th EXPOSE cycle
    begin
      exp_rec_t r;
      r.t_cl = 5; r.len = 0; r.done = 0; r.busy = 0;
      sb_q.push_back(r);
    end
    @(posedge Clk); #1;
    Start = 1'b1; Exp_Time = 5'd5;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    chk("midrst_expose", int'(Expose), 0);
    chk("midrst_busy", int'(Busy), 0);
    chk("midrst_ms_left", int'(Ms_Left), 0);
    chk("midrst_done", int'(Done), 0);
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
    run(5, -1, -1);

    for (int n = 0; n < 10; n++) begin
      int t, sel, k, sb, len;
      t   = $urandom_range(0, 31);
      len = clamp_model(t) * CPM;
      sel = $urandom_range(0, 3);
      k   = (sel == 2) ? $urandom_range(1, len) : (sel == 3) ? len + 1 : -1;
      sb  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len + 1) : -1;
      run(t, k, sb);
    end

`ifdef EXP_TIMER_CONT_EN
    // Three repeats of 2 ms, Cont dropped after the second Done
    begin
      int bad_e, bad_d, bad_b;
      bad_e = 0; bad_d = 0; bad_b = 0;
      mon_en = 1'b0;
      @(posedge Clk); #1;
      Cont = 1'b1; Start = 1'b1; Exp_Time = 5'd2;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int c = 0; c < 34; c++) begin
        if (c == 20) Cont = 1'b0;
        @(negedge Clk);
        if (int'(Expose) != ((c < 30 && (c % 10) >= 1 && (c % 10) <= 8) ? 1 : 0)) bad_e++;
        if (int'(Done) != ((c < 30 && (c % 10) == 9) ? 1 : 0)) bad_d++;
        if (int'(Busy) != ((c < 30) ? 1 : 0)) bad_b++;
        @(posedge Clk); #1;
      end
      chk("cont_expose_pattern_errs", bad_e, 0);
      chk("cont_done_pattern_errs", bad_d, 0);
      chk("cont_busy_pattern_errs", bad_b, 0);
      mon_en = 1'b1;
    end
`endif

    for (int w = 0; w < 20 && Busy; w++) @(posedge Clk);
    #1;
    chk("final_idle", int'(Busy), 0);
    repeat (2) @(posedge Clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
